// File: rtl/mem_pkg.sv
// mem_pkg: shared types and defaults for the mem_interface block.
//   state_e      : controller states IDLE / WAIT / ACCESS / DONE
//   DATA_W_DEF   : default word width
//   ADDR_W_DEF   : default RAM index width (DEPTH = 2**ADDR_W)
//   CNT_W        : wait-state counter width (WAIT_CYCLES 0..15)
package mem_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 9;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;
endpackage

// File: rtl/mem_interface_if.sv
// mem_interface_if: CPU-side MAR/MDR bus of the memory subsystem.
//   MAR_addr, MDR_data, Read, Write : requester -> memory
//   Mdatain, Done, Busy             : memory -> requester
//   addr_err                        : memory -> requester, only with MEM_ADDR_CHECK_EN
// Modports: master (CPU datapath), slave (mem_interface).
interface mem_interface_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] MAR_addr;
    logic [DATA_W-1:0] MDR_data;
    logic              Read;
    logic              Write;
    logic [DATA_W-1:0] Mdatain;
    logic              Done;
    logic              Busy;
`ifdef MEM_ADDR_CHECK_EN
    logic              addr_err;

    modport master (output MAR_addr, MDR_data, Read, Write,
                    input  Mdatain, Done, Busy, addr_err);
    modport slave  (input  MAR_addr, MDR_data, Read, Write,
                    output Mdatain, Done, Busy, addr_err);
`else
    modport master (output MAR_addr, MDR_data, Read, Write,
                    input  Mdatain, Done, Busy);
    modport slave  (input  MAR_addr, MDR_data, Read, Write,
                    output Mdatain, Done, Busy);
`endif
endinterface

// File: rtl/mem_interface_ram_sp.sv
// ram_sp: single-port synchronous RAM, one-cycle registered read.
//   clk   : clock, rising edge
//   we    : write enable
//   addr  : word index
//   wdata : write data
//   rdata : RAM[addr] as of the previous rising edge
// Contents are never reset.
module ram_sp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_interface.sv
// mem_interface: word-addressed memory behind the CPU MAR/MDR.
//   clk   : clock, rising edge
//   clr   : asynchronous active-low reset
//   bus   : mem_interface_if.slave (MAR_addr, MDR_data, Read, Write ->
//           Mdatain, Done, Busy [, addr_err])
// Parameters: DATA_W, ADDR_W, WAIT_CYCLES (0..15 extra wait states).
// Optional feature macro: MEM_ADDR_CHECK_EN -- flags and neutralises
// requests whose MAR_addr has bits set above ADDR_W.
// A request is latched in IDLE, waits WAIT_CYCLES, then ACCESS spends two
// cycles (RAM op, then read-data capture) so Done rises WAIT_CYCLES+2
// edges after the accepting edge.
module mem_interface
    import mem_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            clr,
    mem_interface_if.slave  bus
);
    state_e              state;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                op_wr_q;
    logic                phase_q;   // 0: RAM op issued, 1: read data available
    logic [DATA_W-1:0]   mdatain_q;
    logic                done_q;
    logic                busy_q;
    logic                oor_q;     // latched out-of-range flag
    logic                ram_we;
    logic [DATA_W-1:0]   ram_rdata;
    logic                req_oor;

`ifdef MEM_ADDR_CHECK_EN
    logic                addr_err_q;
    assign req_oor      = (bus.MAR_addr[DATA_W-1:ADDR_W] != '0);
    assign bus.addr_err = addr_err_q;
`else
    assign req_oor      = 1'b0;
`endif

    assign bus.Mdatain = mdatain_q;
    assign bus.Done    = done_q;
    assign bus.Busy    = busy_q;

    // Write strobe only in the first ACCESS cycle, so an abort before ACCESS
    // never touches RAM.
    assign ram_we = (state == ACCESS) && !phase_q && op_wr_q && !oor_q;

    ram_sp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_wr_q    <= 1'b0;
            phase_q    <= 1'b0;
            mdatain_q  <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            oor_q      <= 1'b0;
`ifdef MEM_ADDR_CHECK_EN
            addr_err_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Read || bus.Write) begin
                        addr_q  <= bus.MAR_addr[ADDR_W-1:0];
                        wdata_q <= bus.MDR_data;
                        op_wr_q <= bus.Write;   // Write wins over Read
                        oor_q   <= req_oor;
                        phase_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            state <= WAIT;
                            cnt   <= CNT_W'(WAIT_CYCLES - 1);
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0)
                        state <= ACCESS;
                    else
                        cnt <= cnt - 1'b1;
                end
                ACCESS: begin
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                        if (!op_wr_q)
                            mdatain_q <= oor_q ? '0 : ram_rdata;
                        done_q <= 1'b1;
`ifdef MEM_ADDR_CHECK_EN
                        addr_err_q <= oor_q;
`endif
                        state  <= DONE;
                    end
                end
                DONE: begin
                    // Requester must drop both strobes before a new access.
                    if (!bus.Read && !bus.Write) begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                        busy_q <= 1'b0;
`ifdef MEM_ADDR_CHECK_EN
                        addr_err_q <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
